// File: rtl/ahb_sram_slave_if.sv
// AHB bus bundle between a master and the SRAM slave.
// Signal names keep the slave's point of view (i_ driven by master, o_ driven by slave).
interface ahb_sram_slave_if #(
    parameter int unsigned DATA_WDT = 32
);
    logic                i_hsel;
    logic [31:0]         i_haddr;
    logic [1:0]          i_htrans;
    logic [2:0]          i_hburst;
    logic [2:0]          i_hsize;
    logic                i_hwrite;
    logic [DATA_WDT-1:0] i_hwdata;
    logic                i_hready;
    logic [DATA_WDT-1:0] o_hrdata;
    logic                o_hready;
    logic [1:0]          o_hresp;

    modport master (
        output i_hsel, i_haddr, i_htrans, i_hburst, i_hsize, i_hwrite, i_hwdata, i_hready,
        input  o_hrdata, o_hready, o_hresp
    );

    modport slave (
        input  i_hsel, i_haddr, i_htrans, i_hburst, i_hsize, i_hwrite, i_hwdata, i_hready,
        output o_hrdata, o_hready, o_hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB memory target backed by a word-addressed RAM.
// Pipelined address/data phases, optional wait states, two-cycle ERROR response,
// and write-to-read forwarding so back-to-back write/read of one word needs no stall.
module ahb_sram_slave #(
    parameter int unsigned DATA_WDT    = 32,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic             i_hclk,
    input logic             i_hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned NumWords = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    pend_wr_q, pend_wr_d;
    logic [DEPTH_LOG2-1:0]   pend_idx_q, pend_idx_d;
    logic [3:0]              pend_be_q, pend_be_d;
    logic [DATA_WDT-1:0]     hrdata_q, hrdata_d;

    logic [DATA_WDT-1:0]     mem [NumWords];

    logic                    hready_out;
    logic                    accept;
    logic                    commit;
    logic                    range_err;
    logic                    size_err;
    logic                    acc_err;
    logic [3:0]              acc_be;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [DATA_WDT-1:0]     fwd_word;
    logic                    unused_bits;

    // Burst type and the SEQ/NONSEQ distinction carry no meaning for a plain memory.
    assign unused_bits = ^{bus.i_hburst, bus.i_htrans[0]};

    // Data phase is finished whenever the slave is not stretching it.
    assign hready_out = (state_q == StIdle) || (state_q == StErr2);
    assign accept     = bus.i_hsel & bus.i_hready & bus.i_htrans[1] & hready_out;
    // A pending write retires on the cycle its data phase completes with OKAY.
    assign commit     = pend_wr_q & (state_q == StIdle);
    assign acc_idx    = bus.i_haddr[DEPTH_LOG2+1:2];
    assign range_err  = bus.i_haddr[31:DEPTH_LOG2+2] != '0;
    assign acc_err    = range_err | size_err;

    assign bus.o_hready = hready_out;
    assign bus.o_hresp  = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
    assign bus.o_hrdata = hrdata_q;

    // Byte enables and alignment check for the transfer in its address phase.
    always_comb begin
        acc_be   = 4'b0000;
        size_err = 1'b0;
        case (bus.i_hsize)
            3'b000: acc_be = 4'b0001 << bus.i_haddr[1:0];
            3'b001: begin
                acc_be   = bus.i_haddr[1] ? 4'b1100 : 4'b0011;
                size_err = bus.i_haddr[0];
            end
            3'b010: begin
                acc_be   = 4'b1111;
                size_err = |bus.i_haddr[1:0];
            end
            default: size_err = 1'b1;
        endcase
    end

    // RAM read for the accepted address, merged with a write retiring on the same edge.
    always_comb begin
        fwd_word = mem[acc_idx];
        if (commit && (pend_idx_q == acc_idx)) begin
            for (int k = 0; k < 4; k++) begin
                if (pend_be_q[k]) begin
                    fwd_word[8*k +: 8] = bus.i_hwdata[8*k +: 8];
                end
            end
        end
    end

    // Next-state logic: wait countdown, error sequencing and address-phase capture.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pend_wr_d  = pend_wr_q;
        pend_idx_d = pend_idx_q;
        pend_be_d  = pend_be_q;
        hrdata_d   = hrdata_q;

        if (commit) begin
            pend_wr_d = 1'b0;
        end

        unique case (state_q)
            StWait: begin
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = StIdle;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StErr1: state_d = StErr2;
            default: ;
        endcase

        if (hready_out) begin
            state_d = StIdle;
            if (accept) begin
                if (acc_err) begin
                    state_d   = StErr1;
                    pend_wr_d = 1'b0;
                end else begin
                    if (WAIT_STATES != 0) begin
                        state_d    = StWait;
                        wait_cnt_d = 4'(WAIT_STATES);
                    end
                    pend_wr_d  = bus.i_hwrite;
                    pend_idx_d = acc_idx;
                    pend_be_d  = acc_be;
                    if (!bus.i_hwrite) begin
                        hrdata_d = fwd_word;
                    end
                end
            end
        end
    end

    // Control and data-phase registers.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            pend_wr_q  <= 1'b0;
            pend_idx_q <= '0;
            pend_be_q  <= 4'b0000;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pend_wr_q  <= pend_wr_d;
            pend_idx_q <= pend_idx_d;
            pend_be_q  <= pend_be_d;
            hrdata_q   <= hrdata_d;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge i_hclk) begin
        if (!i_hreset && commit) begin
            for (int k = 0; k < 4; k++) begin
                if (pend_be_q[k]) begin
                    mem[pend_idx_q][8*k +: 8] <= bus.i_hwdata[8*k +: 8];
                end
            end
        end
    end
endmodule
